// File: rtl/ubio_alu_pkg.sv
// Shared definitions for the uBio ALU family: opcodes, sequencer states and flag bundle.
// Imported by the ALU, its iterative engine, the decoder and the control unit.
package ubio_alu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ORI  = 8'h0A;
    localparam logic [7:0] OP_ANDI = 8'h0C;
    localparam logic [7:0] OP_ADD  = 8'h12;
    localparam logic [7:0] OP_SUB  = 8'h13;
    localparam logic [7:0] OP_MUL  = 8'h14;
    localparam logic [7:0] OP_ADDI = 8'h15;
    localparam logic [7:0] OP_DIV  = 8'h16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } alu_state_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } alu_flags_t;

    // Every opcode other than MUL/DIV completes through FIN on the next edge.
    function automatic alu_state_t first_state(input logic [7:0] ctl);
        case (ctl)
            OP_MUL:  return ST_MUL;
            OP_DIV:  return ST_DIV;
            default: return ST_FIN;
        endcase
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Shared iterative engine: shift-add unsigned multiply and restoring unsigned divide.
// The accumulator holds {high, low} = {partial product, multiplier} or {remainder, quotient}.
module alu_iter
    import ubio_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               div_mode,
    input  logic               step,
    input  logic [WIDTH-1:0]   load_a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      cnt;
    logic               mode_q;
    logic [WIDTH:0]     hi_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] div_nxt;

    assign last = (cnt == CW'(WIDTH - 1));

    // Multiply: add multiplicand into the high half when the current multiplier bit is set, then shift right.
    assign hi_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    assign mul_nxt = {hi_sum, acc[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and keep the difference when it does not borrow.
    // A zero divisor never borrows, so the quotient saturates to all ones and the remainder ends as the dividend.
    assign trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b};
    assign div_nxt = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            acc    <= {{WIDTH{1'b0}}, load_a};
            cnt    <= '0;
            mode_q <= div_mode;
        end else if (step) begin
            acc <= mode_q ? div_nxt : mul_nxt;
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle uBio ALU: registered operands, one-cycle add/sub/logic, iterative MUL/DIV.
// Results and flags change only on the edge that raises done; WIDTH must be >= 4 and even.
module alu_mc
    import ubio_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       alu_ctl,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] iv16,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int MSB = WIDTH - 1;

    alu_state_t         state;
    logic [7:0]         ctl_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   iv_q;
    alu_flags_t         flags_q;

    logic               accept;
    logic               iter_load;
    logic               iter_step;
    logic               iter_last;
    logic [2*WIDTH-1:0] iter_acc;

    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;

    logic               upd;
    logic [WIDTH-1:0]   nxt_res;
    logic [WIDTH-1:0]   nxt_res2;
    alu_flags_t         nxt_flags;

    assign busy      = (state != ST_IDLE);
    assign accept    = start && (state == ST_IDLE);
    assign iter_load = accept && ((alu_ctl == OP_MUL) || (alu_ctl == OP_DIV));
    assign iter_step = (state == ST_MUL) || (state == ST_DIV);

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .div_mode (alu_ctl == OP_DIV),
        .step     (iter_step),
        .load_a   (opa),
        .b        (b_q),
        .acc      (iter_acc),
        .last     (iter_last)
    );

    // ADD and ADDI share one adder; ADDI swaps in opb+iv16.
    assign add_x    = (ctl_q == OP_ADDI) ? b_q  : a_q;
    assign add_y    = (ctl_q == OP_ADDI) ? iv_q : b_q;
    assign add_sum  = {1'b0, add_x} + {1'b0, add_y};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        upd       = 1'b1;
        nxt_res   = '0;
        nxt_res2  = '0;
        nxt_flags = '0;
        case (ctl_q)
            OP_ADD, OP_ADDI: begin
                nxt_res     = add_sum[MSB:0];
                nxt_flags.c = add_sum[WIDTH];
                nxt_flags.v = (add_x[MSB] == add_y[MSB]) && (add_sum[MSB] != add_x[MSB]);
            end
            OP_SUB: begin
                nxt_res     = sub_diff[MSB:0];
                nxt_flags.c = sub_diff[WIDTH];
                nxt_flags.v = (a_q[MSB] != b_q[MSB]) && (sub_diff[MSB] != a_q[MSB]);
            end
            OP_ORI:  nxt_res = b_q | iv_q;
            OP_ANDI: nxt_res = b_q & iv_q;
            OP_MUL: begin
                nxt_res     = iter_acc[MSB:0];
                nxt_res2    = iter_acc[2*WIDTH-1:WIDTH];
                nxt_flags.c = |iter_acc[2*WIDTH-1:WIDTH];
                nxt_flags.v = |iter_acc[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                nxt_res     = iter_acc[MSB:0];
                nxt_res2    = iter_acc[2*WIDTH-1:WIDTH];
                nxt_flags.v = (b_q == '0);
            end
            OP_NOP:  upd = 1'b0;
            default: upd = 1'b0;
        endcase
        nxt_flags.z = (nxt_res == '0);
        nxt_flags.n = nxt_res[MSB];
        if (ctl_q == OP_MUL) begin
            nxt_flags.z = (iter_acc == '0);
            nxt_flags.n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            iv_q    <= '0;
            result  <= '0;
            result2 <= '0;
            flags_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ctl_q <= alu_ctl;
                        a_q   <= opa;
                        b_q   <= opb;
                        iv_q  <= iv16;
                        state <= first_state(alu_ctl);
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (iter_last) state <= ST_FIN;
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (upd) begin
                        result  <= nxt_res;
                        result2 <= nxt_res2;
                        flags_q <= nxt_flags;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign C = flags_q.c;
    assign V = flags_q.v;
    assign Z = flags_q.z;
    assign N = flags_q.n;

endmodule
